// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared constants and state encoding for the nibble-serial adder
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter width for n nibbles, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/RCA_4bit.sv
// rtl/RCA_4bit.sv - 4-bit ripple-carry adder, purely combinational
module RCA_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   always_comb begin
      logic c;
      c   = cin;
      sum = '0;
      for (int i = 0; i < 4; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder that reuses one RCA_4bit over WIDTH/4 cycles
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int N     = WIDTH / NIBBLE_W;
   localparam int IDX_W = idx_width(N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   generate
      if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
         $error("nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic [NIBBLE_W-1:0] nib_a, nib_b, rca_sum;
   logic                rca_cout;
   logic                accept;
   logic                last_nibble;

   assign accept      = in_valid && (state_q == IDLE);
   assign last_nibble = (idx_q == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)      state_d = RUN;
         RUN:     if (last_nibble) state_d = DONE;
         DONE:    if (out_ready)   state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // Handshake outputs come straight from state so there is no in->out comb path.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q == RUN) || (state_q == DONE);
   end

   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int k = 0; k < N; k++) begin
         if (idx_q == IDX_W'(k)) begin
            nib_a = op_a_q[k*NIBBLE_W +: NIBBLE_W];
            nib_b = op_b_q[k*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   RCA_4bit u_rca (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_q),
      .sum  (rca_sum),
      .cout (rca_cout)
   );

   always_comb begin
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      if (accept) begin
         op_a_d  = a;
         op_b_d  = b;
         sum_d   = '0;
         carry_d = cin;
         idx_d   = '0;
      end else if (state_q == RUN) begin
         for (int k = 0; k < N; k++) begin
            if (idx_q == IDX_W'(k)) begin
               sum_d[k*NIBBLE_W +: NIBBLE_W] = rca_sum;
            end
         end
         carry_d = rca_cout;
         idx_d   = last_nibble ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_q  <= '0;
         op_b_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
      end
   end

   assign sum  = sum_q;
   assign cout = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed and randomized checks of nibble_serial_adder
module tb_nibble_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
   logic [15:0] a, b, sum;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, busy8;
   logic [7:0]  a8, b8, sum8;

   int checks = 0;
   int errors = 0;

   nibble_serial_adder #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   nibble_serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .cout(cout8), .busy(busy8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [15:0] va, input logic [15:0] vb, input logic vc);
      int guard;
      guard = 0;
      while (!in_ready && guard < 20) begin
         tick();
         guard++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      a = va; b = vb; cin = vc; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
      chk("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   // Reference: plain (WIDTH+1)-bit arithmetic.
   task automatic finish_txn(input string tag, input logic [15:0] va, input logic [15:0] vb,
                             input logic vc, input int stall);
      logic [16:0] exp;
      exp = {1'b0, va} + {1'b0, vb} + 17'(vc);
      for (int s = 0; s < stall; s++) tick();
      chk({tag, "_sum"},  32'(sum),  32'(exp[15:0]));
      chk({tag, "_cout"}, 32'(cout), 32'(exp[16]));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_released"}, 32'({out_valid, in_ready, busy}), 32'b010);
   endtask

   task automatic txn(input string tag, input logic [15:0] va, input logic [15:0] vb,
                      input logic vc, input int stall);
      int lat;
      start(va, vb, vc);
      wait_out(lat);
      chk({tag, "_latency"}, 32'(lat), 32'd4);
      finish_txn(tag, va, vb, vc, stall);
   endtask

   initial begin
      int          lat, t1, t2, cyc;
      logic [15:0] ra, rb, hold_sum;
      logic        rc, hold_cout;

      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      #3;
      chk("reset_outputs", 32'({out_valid, busy, cout, sum}), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      chk("post_reset_in_ready", 32'(in_ready), 32'd1);

      txn("t_0_1",      16'h0000, 16'h0001, 1'b0, 0);
      txn("t_3_6_cin",  16'h0003, 16'h0006, 1'b1, 0);
      txn("t_ffff_1",   16'hFFFF, 16'h0001, 1'b0, 0);
      txn("t_8000x2",   16'h8000, 16'h8000, 1'b0, 0);
      txn("t_ffff_cin", 16'hFFFF, 16'hFFFF, 1'b1, 0);

      // Backpressure with stray in_valid traffic during RUN and DONE.
      start(16'h1357, 16'h2468, 1'b1);
      chk("busy_in_run", 32'({busy, in_ready}), 32'b10);
      in_valid = 1'b1; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0;
      wait_out(lat);
      chk("bp_latency", 32'(lat), 32'd4);
      hold_sum = sum; hold_cout = cout;
      for (int s = 0; s < 5; s++) begin
         in_valid = ~in_valid;
         a = 16'($urandom);
         tick();
         chk("bp_stable", 32'({out_valid, in_ready, busy, cout, sum}),
             32'({1'b1, 1'b0, 1'b1, hold_cout, hold_sum}));
      end
      in_valid = 1'b0;
      finish_txn("bp", 16'h1357, 16'h2468, 1'b1, 0);

      // Asynchronous reset after two nibbles have been processed.
      start(16'hAAAA, 16'h5555, 1'b1);
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrun_reset", 32'({out_valid, busy, cout, sum}), 32'd0);
      tick();
      rst_n = 1'b1;
      txn("after_reset", 16'h1234, 16'h4321, 1'b0, 0);

      for (int i = 0; i < 24; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         txn("rand", ra, rb, rc, int'($urandom_range(0, 3)));
      end

      // WIDTH=8 back-to-back with both handshakes held high.
      a8 = 8'hF0; b8 = 8'h10; cin8 = 1'b0;
      in_valid8 = 1'b1; out_ready8 = 1'b1;
      tick();
      a8 = 8'h7F; b8 = 8'h01;
      cyc = 1;
      while (!out_valid8 && cyc < 30) begin tick(); cyc++; end
      t1 = cyc;
      chk("w8_first", 32'({out_valid8, cout8, sum8}), 32'({1'b1, 1'b1, 8'h00}));
      tick(); cyc++;
      while (!out_valid8 && cyc < 60) begin tick(); cyc++; end
      t2 = cyc;
      in_valid8 = 1'b0;
      chk("w8_second", 32'({out_valid8, cout8, sum8}), 32'({1'b1, 1'b0, 8'h80}));
      chk("w8_spacing", 32'(t2 - t1), 32'd4);
      tick();
      out_ready8 = 1'b0;
      chk("w8_idle", 32'({out_valid8, in_ready8}), 32'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
